// File: rtl/pcie_scrambler_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pcie_scrambler_pkg
// Purpose  : Symbol constants and the 8-shift Galois LFSR step shared by the
//            PCIe Gen1/Gen2 transmit scrambler.
// Revision : 1.0  initial release
// ============================================================================
package pcie_scrambler_pkg;

  localparam logic [7:0]  SYM_COM           = 8'hBC;
  localparam logic [7:0]  SYM_SKP           = 8'h1C;
  localparam logic [15:0] LFSR_SEED_DEFAULT = 16'hFFFF;
  localparam logic [15:0] LFSR_TAP_MASK     = 16'h0038;

  typedef struct packed {
    logic [15:0] lfsr;
    logic [7:0]  scr;
  } lfsr_step_t;

  // Bit i of scr is the LFSR output of shift i, so data bit 0 meets the oldest output.
  function automatic lfsr_step_t lfsr_shift8(input logic [15:0] lfsr_in);
    lfsr_step_t res;
    logic [15:0] s;
    logic        out;
    s       = lfsr_in;
    res.scr = '0;
    for (int i = 0; i < 8; i++) begin
      out        = s[15];
      res.scr[i] = out;
      s          = {s[14:0], 1'b0} ^ ({16{out}} & (LFSR_TAP_MASK | 16'h0001));
    end
    res.lfsr = s;
    return res;
  endfunction

endpackage : pcie_scrambler_pkg
`default_nettype wire

// File: rtl/pcie_scrambler_byte_step.sv
`default_nettype none
// ============================================================================
// Module   : pcie_scrambler_byte_step
// Purpose  : Combinational scramble of one symbol plus the LFSR update for it.
// Revision : 1.0  initial release
// ============================================================================
module pcie_scrambler_byte_step
  import pcie_scrambler_pkg::*;
#(
  parameter logic [15:0] LFSR_SEED = LFSR_SEED_DEFAULT
) (
  input  logic [15:0] lfsr_in,
  input  logic [7:0]  data,
  input  logic        k,
  input  logic        ts,
  input  logic        dis,
  output logic [15:0] lfsr_out,
  output logic [7:0]  data_out
);

  lfsr_step_t w_step;

  assign w_step = lfsr_shift8(lfsr_in);

  // First matching rule wins; dis only suppresses the XOR, never the LFSR update.
  always_comb begin
    lfsr_out = w_step.lfsr;
    data_out = data;
    if (k && (data == SYM_COM)) begin
      lfsr_out = LFSR_SEED;
    end else if (k && (data == SYM_SKP)) begin
      lfsr_out = lfsr_in;
    end else if (!k && !ts && !dis) begin
      data_out = data ^ w_step.scr;
    end
  end

endmodule : pcie_scrambler_byte_step
`default_nettype wire

// File: rtl/pcie_scrambler_lanes.sv
`default_nettype none
// ============================================================================
// Module   : pcie_scrambler_lanes
// Purpose  : NUM_BYTES-wide PCIe 8b/10b transmit scrambler with its own LFSR
//            and one clock of registered latency. Defining SCRAMBLER_DEBUG_EN
//            adds the lfsr_state_o and com_count_o debug outputs.
// Revision : 1.0  initial release
// ============================================================================
module pcie_scrambler_lanes
  import pcie_scrambler_pkg::*;
#(
  parameter int          NUM_BYTES = 4,
  parameter logic [15:0] LFSR_SEED = LFSR_SEED_DEFAULT
) (
  input  logic                   clk_i,
  input  logic                   rst_n_i,
  input  logic                   valid_i,
  input  logic [8*NUM_BYTES-1:0] data_i,
  input  logic [NUM_BYTES-1:0]   datak_i,
  input  logic [NUM_BYTES-1:0]   training_sequence_i,
  input  logic                   scramble_dis_i,
`ifdef SCRAMBLER_DEBUG_EN
  output logic [15:0]            lfsr_state_o,
  output logic [15:0]            com_count_o,
`endif
  output logic                   valid_o,
  output logic [8*NUM_BYTES-1:0] data_o,
  output logic [NUM_BYTES-1:0]   datak_o
);

  logic [15:0]            w_lfsr_chain [NUM_BYTES+1];
  logic [8*NUM_BYTES-1:0] w_data_scr;

  logic                   r_valid;
  logic [8*NUM_BYTES-1:0] r_data;
  logic [NUM_BYTES-1:0]   r_datak;
  logic [15:0]            r_lfsr;

  assign w_lfsr_chain[0] = r_lfsr;

  // Byte 0 is first on the wire, so the LFSR ripples upward through the word.
  generate
    for (genvar g = 0; g < NUM_BYTES; g++) begin : g_byte
      pcie_scrambler_byte_step #(
        .LFSR_SEED (LFSR_SEED)
      ) u_step (
        .lfsr_in  (w_lfsr_chain[g]),
        .data     (data_i[8*g +: 8]),
        .k        (datak_i[g]),
        .ts       (training_sequence_i[g]),
        .dis      (scramble_dis_i),
        .lfsr_out (w_lfsr_chain[g+1]),
        .data_out (w_data_scr[8*g +: 8])
      );
    end
  endgenerate

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_valid <= 1'b0;
      r_data  <= '0;
      r_datak <= '0;
      r_lfsr  <= LFSR_SEED;
    end else begin
      r_valid <= valid_i;
      if (valid_i) begin
        r_data  <= w_data_scr;
        r_datak <= datak_i;
        r_lfsr  <= w_lfsr_chain[NUM_BYTES];
      end
    end
  end

  assign valid_o = r_valid;
  assign data_o  = r_data;
  assign datak_o = r_datak;

`ifdef SCRAMBLER_DEBUG_EN
  logic [NUM_BYTES-1:0] w_com_hit;
  logic [4:0]           w_com_inc;
  logic [16:0]          w_com_sum;
  logic [15:0]          r_com_count;

  generate
    for (genvar g = 0; g < NUM_BYTES; g++) begin : g_com_hit
      assign w_com_hit[g] = datak_i[g] && (data_i[8*g +: 8] == SYM_COM);
    end
  endgenerate

  always_comb begin
    w_com_inc = '0;
    for (int i = 0; i < NUM_BYTES; i++) begin
      w_com_inc = w_com_inc + {4'b0000, w_com_hit[i]};
    end
  end

  assign w_com_sum = {1'b0, r_com_count} + {12'b0, w_com_inc};

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_com_count <= '0;
    end else if (valid_i) begin
      r_com_count <= w_com_sum[16] ? 16'hFFFF : w_com_sum[15:0];
    end
  end

  assign lfsr_state_o = r_lfsr;
  assign com_count_o  = r_com_count;
`endif

endmodule : pcie_scrambler_lanes
`default_nettype wire

// File: tb/tb_pcie_scrambler_lanes.sv
`default_nettype none
// ============================================================================
// Module   : tb_pcie_scrambler_lanes
// Purpose  : Directed self-checking bench for the 4-byte scrambler.
// Revision : 1.0  initial release
// ============================================================================
module tb_pcie_scrambler_lanes;

  localparam int NB = 4;

  logic          clk;
  logic          rst_n;
  logic          valid_in;
  logic [8*NB-1:0] data_in;
  logic [NB-1:0] datak_in;
  logic [NB-1:0] ts_in;
  logic          dis_in;
  logic          valid_out;
  logic [8*NB-1:0] data_out;
  logic [NB-1:0] datak_out;
`ifdef SCRAMBLER_DEBUG_EN
  logic [15:0]   lfsr_state;
  logic [15:0]   com_count;
`endif

  int checks   = 0;
  int failures = 0;

  pcie_scrambler_lanes #(
    .NUM_BYTES (NB),
    .LFSR_SEED (16'hFFFF)
  ) dut (
    .clk_i               (clk),
    .rst_n_i             (rst_n),
    .valid_i             (valid_in),
    .data_i              (data_in),
    .datak_i             (datak_in),
    .training_sequence_i (ts_in),
    .scramble_dis_i      (dis_in),
`ifdef SCRAMBLER_DEBUG_EN
    .lfsr_state_o        (lfsr_state),
    .com_count_o         (com_count),
`endif
    .valid_o             (valid_out),
    .data_o              (data_out),
    .datak_o             (datak_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Apply one word at the falling edge and sample 1 ns after the next rising edge.
  task automatic drive(input logic v, input logic [31:0] d, input logic [3:0] k,
                       input logic [3:0] ts, input logic dis);
    @(negedge clk);
    valid_in = v;
    data_in  = d;
    datak_in = k;
    ts_in    = ts;
    dis_in   = dis;
    @(posedge clk);
    #1;
  endtask

  task automatic com_word();
    drive(1'b1, 32'h000000BC, 4'b0001, 4'b0000, 1'b0);
  endtask

  task automatic test_reset();
    checks++;
    if (valid_out !== 1'b0) begin
      failures++;
      $display("FAIL reset_valid: got %b expected 0", valid_out);
    end
    checks++;
    if (data_out !== 32'h0) begin
      failures++;
      $display("FAIL reset_data: got %h expected 00000000", data_out);
    end
    checks++;
    if (datak_out !== 4'h0) begin
      failures++;
      $display("FAIL reset_datak: got %b expected 0000", datak_out);
    end
  endtask

  task automatic test_com_sequence();
    com_word();
    checks++;
    if (valid_out !== 1'b1 || data_out !== 32'hC017FFBC || datak_out !== 4'b0001) begin
      failures++;
      $display("FAIL com_word0: got v=%b d=%h k=%b expected v=1 d=C017FFBC k=0001",
               valid_out, data_out, datak_out);
    end
    drive(1'b1, 32'h0, 4'b0000, 4'b0000, 1'b0);
    checks++;
    if (data_out !== 32'h02E7B214 || datak_out !== 4'b0000) begin
      failures++;
      $display("FAIL com_word1: got d=%h k=%b expected d=02E7B214 k=0000", data_out, datak_out);
    end
    drive(1'b1, 32'h0, 4'b0000, 4'b0000, 1'b0);
    checks++;
    if (data_out !== 32'h286E7282) begin
      failures++;
      $display("FAIL com_word2: got %h expected 286E7282", data_out);
    end
  endtask

  task automatic test_skp();
    com_word();
    drive(1'b1, 32'h1C1C1C1C, 4'b1111, 4'b0000, 1'b0);
    checks++;
    if (data_out !== 32'h1C1C1C1C || datak_out !== 4'b1111) begin
      failures++;
      $display("FAIL skp_pass: got d=%h k=%b expected d=1C1C1C1C k=1111", data_out, datak_out);
    end
    drive(1'b1, 32'h1C1C1C1C, 4'b1111, 4'b0000, 1'b0);
    drive(1'b1, 32'h0, 4'b0000, 4'b0000, 1'b0);
    checks++;
    if (data_out !== 32'h02E7B214) begin
      failures++;
      $display("FAIL skp_continue: got %h expected 02E7B214", data_out);
    end
  endtask

  task automatic test_com_mid();
    com_word();
    drive(1'b1, 32'h00BC0000, 4'b0100, 4'b0000, 1'b0);
    checks++;
    if (data_out !== 32'hFFBCB214 || datak_out !== 4'b0100) begin
      failures++;
      $display("FAIL com_mid: got d=%h k=%b expected d=FFBCB214 k=0100", data_out, datak_out);
    end
    drive(1'b1, 32'h0, 4'b0000, 4'b0000, 1'b0);
    checks++;
    if (data_out !== 32'hB214C017) begin
      failures++;
      $display("FAIL com_mid_next: got %h expected B214C017", data_out);
    end
  endtask

  task automatic test_com_last();
    drive(1'b1, 32'hBC123456, 4'b1000, 4'b0000, 1'b0);
    drive(1'b1, 32'h0, 4'b0000, 4'b0000, 1'b0);
    checks++;
    if (data_out !== 32'h14C017FF) begin
      failures++;
      $display("FAIL com_last_next: got %h expected 14C017FF", data_out);
    end
  endtask

  task automatic test_training_sequence();
    drive(1'b1, 32'h4A4A4ABC, 4'b0001, 4'b1110, 1'b0);
    checks++;
    if (data_out !== 32'h4A4A4ABC) begin
      failures++;
      $display("FAIL ts_pass: got %h expected 4A4A4ABC", data_out);
    end
    drive(1'b1, 32'h0, 4'b0000, 4'b0000, 1'b0);
    checks++;
    if (data_out !== 32'h02E7B214) begin
      failures++;
      $display("FAIL ts_advance: got %h expected 02E7B214", data_out);
    end
  endtask

  task automatic test_disable();
    com_word();
    drive(1'b1, 32'h12345678, 4'b0000, 4'b0000, 1'b1);
    checks++;
    if (data_out !== 32'h12345678 || valid_out !== 1'b1) begin
      failures++;
      $display("FAIL dis_raw: got v=%b d=%h expected v=1 d=12345678", valid_out, data_out);
    end
    drive(1'b1, 32'h0, 4'b0000, 4'b0000, 1'b0);
    checks++;
    if (data_out !== 32'h286E7282) begin
      failures++;
      $display("FAIL dis_in_step: got %h expected 286E7282", data_out);
    end
  endtask

  task automatic test_valid_gap();
    com_word();
    drive(1'b0, 32'hDEADBEEF, 4'b1010, 4'b0000, 1'b0);
    checks++;
    if (valid_out !== 1'b0 || data_out !== 32'hC017FFBC || datak_out !== 4'b0001) begin
      failures++;
      $display("FAIL gap_hold: got v=%b d=%h k=%b expected v=0 d=C017FFBC k=0001",
               valid_out, data_out, datak_out);
    end
    drive(1'b1, 32'h0, 4'b0000, 4'b0000, 1'b0);
    checks++;
    if (valid_out !== 1'b1 || data_out !== 32'h02E7B214) begin
      failures++;
      $display("FAIL gap_resume: got v=%b d=%h expected v=1 d=02E7B214", valid_out, data_out);
    end
  endtask

  task automatic test_async_reset();
    com_word();
    drive(1'b1, 32'h0, 4'b0000, 4'b0000, 1'b0);
    @(negedge clk);
    data_in  = 32'h000000BC;
    datak_in = 4'b0001;
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (valid_out !== 1'b0 || data_out !== 32'h0 || datak_out !== 4'b0) begin
      failures++;
      $display("FAIL async_reset: got v=%b d=%h k=%b expected v=0 d=00000000 k=0000",
               valid_out, data_out, datak_out);
    end
    valid_in = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    drive(1'b1, 32'h0, 4'b0000, 4'b0000, 1'b0);
    checks++;
    if (data_out !== 32'h14C017FF || datak_out !== 4'b0000) begin
      failures++;
      $display("FAIL reset_seed: got d=%h k=%b expected d=14C017FF k=0000", data_out, datak_out);
    end
  endtask

  initial begin
    rst_n    = 1'b1;
    valid_in = 1'b0;
    data_in  = '0;
    datak_in = '0;
    ts_in    = '0;
    dis_in   = 1'b0;
    #1;
    rst_n = 1'b0;
    #1;
    test_reset();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    test_com_sequence();
    test_skp();
    test_com_mid();
    test_com_last();
    test_training_sequence();
    test_disable();
    test_valid_gap();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_pcie_scrambler_lanes
`default_nettype wire
